sp_census_match: RTL and testbench

Streaming census matcher: consumes synchronised left/right 8-bit sparse census code streams and produces, per left pixel, a winner-takes-all disparity found by minimum Hamming distance. Only right-image codes to the left of the current pixel are candidates. Sits directly downstream of the two census transform instances (one per camera), and its output feeds the disparity frame buffer. Fixed 2-cycle pipeline; throughput one pixel per clock.

---
 rtl/sp_census_match_if.sv | 32 +++
 rtl/sp_census_match.sv | 85 ++++++++
 tb/tb_sp_census_match.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/sp_census_match_if.sv
// sp_census_match_if: pixel stream bus into and out of the census matcher.
//   max_cost            confidence limit (4b)
//   in_left/in_right    left/right census codes of the same (x,y) (8b each)
//   in_x/in_y           input pixel coordinates (10b each)
//   is_in_val           input pixel valid, single-cycle qualifier
//   out_disp/out_cost   winning disparity (8b) and its Hamming cost (4b)
//   out_conf            winner cost within the confidence limit
//   out_x/out_y         output pixel coordinates (10b each)
//   is_out_val          output pixel valid
//   modport master: the pixel source/sink side; modport slave: the matcher.
interface sp_census_match_if;
   logic [3:0] max_cost;
   logic [7:0] in_left;
   logic [7:0] in_right;
   logic [9:0] in_x;
   logic [9:0] in_y;
   logic       is_in_val;
   logic [7:0] out_disp;
   logic [3:0] out_cost;
   logic       out_conf;
   logic [9:0] out_x;
   logic [9:0] out_y;
   logic       is_out_val;
   modport master (
      output max_cost, in_left, in_right, in_x, in_y, is_in_val,
      input  out_disp, out_cost, out_conf, out_x, out_y, is_out_val
   );
   modport slave (
      input  max_cost, in_left, in_right, in_x, in_y, is_in_val,
      output out_disp, out_cost, out_conf, out_x, out_y, is_out_val
   );
endinterface

// File: rtl/sp_census_match.sv
// sp_census_match: streaming winner-takes-all census disparity matcher, 2-stage pipeline.
//   clk    clock
//   reset  synchronous active-high reset
//   bus    sp_census_match_if.slave: census code stream in, disparity stream out
module sp_census_match #(
   parameter int ROW_SZ   = 320,
   parameter int COL_SZ   = 240,
   parameter int MAX_DISP = 32
) (
   input logic              clk,
   input logic              reset,
   sp_census_match_if.slave bus
);
   localparam int W = MAX_DISP - 1;
   if (MAX_DISP < 2 || MAX_DISP > 64 || ROW_SZ > 1024 || COL_SZ > 1024) begin : g_bad_param
      $error("sp_census_match: parameter out of range");
   end
   logic [7:0]   win_code [W];
   logic [W-1:0] win_val;
   logic [3:0]   cost     [MAX_DISP];
   logic [3:0]   s1_cost  [MAX_DISP];
   logic [9:0]   s1_x;
   logic [9:0]   s1_y;
   logic         s1_val;
   logic [3:0]   mc_q;
   logic [7:0]   best_d;
   logic [3:0]   best_c;
   // Right window: slot k holds the right code from k+1 accepted pixels ago.
   // Valid bits fill from slot 0 so post-reset candidates come online one by one.
   always_ff @(posedge clk)
      if (reset) begin
         win_val <= '0;
         for (int i = 0; i < W; i++) win_code[i] <= '0;
      end else if (bus.is_in_val) begin
         win_code[0] <= bus.in_right;
         for (int i = 1; i < W; i++) win_code[i] <= win_code[i-1];
         win_val <= (win_val << 1) | W'(1);
      end
   // d=0 is always live; d>=1 needs a filled slot and must not reach past the row start.
   assign cost[0] = 4'($countones(bus.in_left ^ bus.in_right));
   for (genvar d = 1; d < MAX_DISP; d++) begin : g_cost
      assign cost[d] = (win_val[d-1] && 10'(d) <= bus.in_x)
                       ? 4'($countones(bus.in_left ^ win_code[d-1])) : 4'd15;
   end
   always_ff @(posedge clk)
      if (reset) s1_val <= 1'b0;
      else begin
         s1_val <= bus.is_in_val;
         if (bus.is_in_val) begin
            s1_cost <= cost;
            s1_x    <= bus.in_x;
            s1_y    <= bus.in_y;
         end
      end
   // Strict less-than while scanning upward keeps the smallest d on ties.
   always_comb begin
      best_c = s1_cost[0];
      best_d = '0;
      for (int i = 1; i < MAX_DISP; i++)
         if (s1_cost[i] < best_c) begin
            best_c = s1_cost[i];
            best_d = 8'(i);
         end
   end
   always_ff @(posedge clk)
      if (reset) begin
         mc_q           <= '0;
         bus.is_out_val <= 1'b0;
         bus.out_disp   <= '0;
         bus.out_cost   <= '0;
         bus.out_conf   <= 1'b0;
         bus.out_x      <= '0;
         bus.out_y      <= '0;
      end else begin
         mc_q           <= bus.max_cost;
         bus.is_out_val <= s1_val;
         if (s1_val) begin
            bus.out_disp <= best_d;
            bus.out_cost <= best_c;
            bus.out_conf <= (best_c <= mc_q);
            bus.out_x    <= s1_x;
            bus.out_y    <= s1_y;
         end
      end
endmodule

// File: tb/tb_sp_census_match.sv
// tb_sp_census_match: directed scoreboard bench for sp_census_match.
//   Drives pixels at negedge, predicts each output from a reference candidate
//   search, and compares outputs one tick after each posedge.
module tb_sp_census_match;
   localparam int MD = 32;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;
   sp_census_match_if bus();
   sp_census_match #(.ROW_SZ(320), .COL_SZ(240), .MAX_DISP(MD)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );
   typedef struct {
      logic [7:0] disp;
      logic [3:0] cost;
      logic       conf;
      logic [9:0] x;
      logic [9:0] y;
      int         due;
   } exp_t;
   exp_t       sb[$];
   logic [7:0] rhist[$];
   logic [7:0] lc[400];
   logic [3:0] mc = 4'd2;
   int nval = 0;
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int n_out = 0;
   int n_exp = 0;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // Reference: candidate d>=1 exists once d pixels were accepted since reset and d <= x.
   task automatic send(input logic [7:0] l, input logic [7:0] r, input int x, input int y, input int gap);
      exp_t e;
      int   c;
      @(negedge clk);
      bus.in_left   = l;
      bus.in_right  = r;
      bus.in_x      = 10'(x);
      bus.in_y      = 10'(y);
      bus.is_in_val = 1'b1;
      e.disp = 8'd0;
      e.cost = 4'($countones(l ^ r));
      for (int d = 1; d < MD; d++)
         if (d <= nval && d <= x) begin
            c = $countones(l ^ rhist[d-1]);
            if (c < int'(e.cost)) begin
               e.cost = 4'(c);
               e.disp = 8'(d);
            end
         end
      e.conf = (e.cost <= mc);
      e.x    = 10'(x);
      e.y    = 10'(y);
      e.due  = cyc + 2;
      sb.push_back(e);
      n_exp++;
      rhist.push_front(r);
      if (rhist.size() > MD) void'(rhist.pop_back());
      nval++;
      repeat (gap) begin
         @(negedge clk);
         bus.is_in_val = 1'b0;
      end
   endtask
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.is_in_val = 1'b0;
      end
   endtask
   task automatic gen_codes();
      int b = int'($urandom);
      for (int i = 0; i < 400; i++) lc[i] = 8'(b + i * 167);
   endtask
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (bus.is_out_val) n_out++;
      if (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         chk("out_valid", bus.is_out_val, 1);
         chk($sformatf("disp_x%0d_y%0d", e.x, e.y), bus.out_disp, e.disp);
         chk($sformatf("cost_x%0d_y%0d", e.x, e.y), bus.out_cost, e.cost);
         chk($sformatf("conf_x%0d_y%0d", e.x, e.y), bus.out_conf, e.conf);
         chk("out_x", bus.out_x, e.x);
         chk("out_y", bus.out_y, e.y);
      end else if (bus.is_out_val) begin
         chk("spurious_out", bus.is_out_val, 0);
      end
   end
   initial begin
      bus.max_cost  = mc;
      bus.in_left   = '0;
      bus.in_right  = '0;
      bus.in_x      = '0;
      bus.in_y      = '0;
      bus.is_in_val = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_out_val", bus.is_out_val, 0);
      chk("rst_disp", bus.out_disp, 0);
      chk("rst_cost", bus.out_cost, 0);
      chk("rst_conf", bus.out_conf, 0);
      chk("rst_x", bus.out_x, 0);
      chk("rst_y", bus.out_y, 0);
      reset = 1'b0;
      // identical streams: every winner is d=0 at cost 0
      for (int x = 0; x < 320; x++) begin
         logic [7:0] v = 8'($urandom);
         send(v, v, x, 0, 0);
      end
      // 5-pixel shift, streaming straight through the row boundary
      gen_codes();
      for (int x = 0; x < 320; x++) send(lc[x], lc[x+5], x, 1, 0);
      // same shift with 3-cycle bubbles between pixels
      gen_codes();
      for (int x = 0; x < 64; x++) send(lc[x], lc[x+5], x, 2, 3);
      // ties: fill the window with 0x01 against left 0x00, then d=3 and d=7 both exact
      for (int x = 40; x < 72; x++) send(8'h00, 8'h01, x, 3, 0);
      for (int k = 0; k < 7; k++) send(8'hff, (k == 0 || k == 4) ? 8'h00 : 8'h01, 72 + k, 3, 0);
      send(8'h00, 8'h01, 79, 3, 0);
      idle(2);
      // confidence around max_cost = 2
      send(8'h00, 8'h07, 0, 4, 0);
      send(8'h00, 8'h03, 0, 4, 0);
      send(8'h00, 8'h01, 0, 4, 0);
      idle(2);
      // reset mid-row with a pixel presented in the reset cycle
      gen_codes();
      for (int x = 0; x < 100; x++) send(lc[x], lc[x+5], x, 5, 0);
      @(negedge clk);
      reset         = 1'b1;
      bus.in_left   = lc[100];
      bus.in_right  = lc[105];
      bus.in_x      = 10'd100;
      bus.is_in_val = 1'b1;
      n_exp -= sb.size();
      sb.delete();
      rhist.delete();
      nval = 0;
      @(negedge clk);
      reset         = 1'b0;
      bus.is_in_val = 1'b0;
      for (int x = 101; x < 140; x++) send(lc[x], lc[x+5], x, 5, 0);
      idle(1);
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk("drain", sb.size(), 0);
      chk("out_count", n_out, n_exp);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
